// File: rtl/ws_led_tx.sv
// rtl/ws_led_tx.sv - WS2812-style one-wire NRZ pixel serialiser (optional word prefetch: WS_LED_TX_PREFETCH_EN)
module ws_led_tx #(
    parameter int BITS      = 24,
    parameter int T0H_CYC   = 8,
    parameter int T1H_CYC   = 16,
    parameter int BIT_CYC   = 25,
    parameter int RESET_CYC = 6000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [BITS-1:0] s_data,
    input  logic            s_last,
    output logic            dout,
    output logic            busy
);

    localparam int MAX_CYC = (BIT_CYC > RESET_CYC) ? BIT_CYC : RESET_CYC;
    localparam int CW      = $clog2(MAX_CYC + 1);
    localparam int BW      = $clog2(BITS + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_HIGH  = 2'd1;
    localparam logic [1:0] ST_LOW   = 2'd2;
    localparam logic [1:0] ST_LATCH = 2'd3;

    // Terminal counts: each state runs while cnt_q counts up from 0 to its END value.
    localparam logic [CW-1:0] HI0_END   = CW'(T0H_CYC - 1);
    localparam logic [CW-1:0] HI1_END   = CW'(T1H_CYC - 1);
    localparam logic [CW-1:0] LO0_END   = CW'(BIT_CYC - T0H_CYC - 1);
    localparam logic [CW-1:0] LO1_END   = CW'(BIT_CYC - T1H_CYC - 1);
    localparam logic [CW-1:0] LATCH_END = CW'(RESET_CYC - 1);
    localparam logic [BW-1:0] BITS_INIT = BW'(BITS);

    generate
        if (!(T0H_CYC > 0 && T0H_CYC < T1H_CYC && T1H_CYC < BIT_CYC &&
              RESET_CYC >= 1 && BITS >= 1)) begin : g_cfg_err
            $error("ws_led_tx: illegal timing/width parameters");
        end
    endgenerate

    logic [1:0]      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [BW-1:0]   bit_q, bit_d;
    logic [BITS-1:0] shift_q, shift_d;
    logic            last_q, last_d;
    logic            dout_q;

    logic            xfer;
    logic            load;
    logic [BITS-1:0] load_data;
    logic            load_last;
    logic            cur_one;
    logic [CW-1:0]   high_end;
    logic [CW-1:0]   low_end;

    assign xfer     = s_valid & s_ready;
    assign cur_one  = shift_q[BITS-1];
    assign high_end = cur_one ? HI1_END : HI0_END;
    assign low_end  = cur_one ? LO1_END : LO0_END;
    assign busy     = (state_q != ST_IDLE);
    assign dout     = dout_q;

`ifdef WS_LED_TX_PREFETCH_EN
    logic [BITS-1:0] hold_data_q, hold_data_d;
    logic            hold_last_q, hold_last_d;
    logic            hold_full_q, hold_full_d;
    logic            next_avail;

    // A free hold slot accepts a word anywhere except during the latch gap.
    assign s_ready    = !rst && !hold_full_q && (state_q != ST_LATCH);
    // The held word has priority; an empty hold lets a same-cycle transfer go straight to the shifter.
    assign next_avail = hold_full_q || xfer;
    assign load_data  = hold_full_q ? hold_data_q : s_data;
    assign load_last  = hold_full_q ? hold_last_q : s_last;
`else
    assign s_ready   = !rst && (state_q == ST_IDLE);
    assign load_data = s_data;
    assign load_last = s_last;
`endif

    // Bit-timing FSM: HIGH/LOW per bit, LATCH gap after a frame, shifter load on word start.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        last_d  = last_q;
        load    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
`ifdef WS_LED_TX_PREFETCH_EN
                load  = next_avail;
`else
                load  = xfer;
`endif
            end
            ST_HIGH: begin
                if (cnt_q == high_end) begin
                    state_d = ST_LOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_LOW: begin
                if (cnt_q == low_end) begin
                    cnt_d = '0;
                    if (bit_q == BW'(1)) begin
                        if (last_q) begin
                            state_d = ST_LATCH;
                        end else begin
                            state_d = ST_IDLE;
`ifdef WS_LED_TX_PREFETCH_EN
                            load    = next_avail;
`endif
                        end
                    end else begin
                        state_d = ST_HIGH;
                        bit_d   = bit_q - BW'(1);
                        shift_d = shift_q << 1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_LATCH: begin
                if (cnt_q == LATCH_END) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        if (load) begin
            state_d = ST_HIGH;
            cnt_d   = '0;
            bit_d   = BITS_INIT;
            shift_d = load_data;
            last_d  = load_last;
        end
    end

    // State registers; dout follows the HIGH state one cycle later so the pad sees a clean register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            last_q  <= 1'b0;
            dout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            last_q  <= last_d;
            dout_q  <= (state_q == ST_HIGH);
        end
    end

`ifdef WS_LED_TX_PREFETCH_EN
    // Hold slot: emptied when the shifter takes it, refilled by any transfer not consumed directly.
    always_comb begin
        hold_data_d = hold_data_q;
        hold_last_d = hold_last_q;
        hold_full_d = hold_full_q;
        if (load && hold_full_q) begin
            hold_full_d = 1'b0;
        end
        if (xfer && !(load && !hold_full_q)) begin
            hold_data_d = s_data;
            hold_last_d = s_last;
            hold_full_d = 1'b1;
        end
    end

    // Hold register storage; reset discards any pending word.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_data_q <= '0;
            hold_last_q <= 1'b0;
            hold_full_q <= 1'b0;
        end else begin
            hold_data_q <= hold_data_d;
            hold_last_q <= hold_last_d;
            hold_full_q <= hold_full_d;
        end
    end
`endif

endmodule

// File: tb/tb_ws_led_tx.sv
// tb/tb_ws_led_tx.sv - directed self-checking bench for ws_led_tx (small and default parameter instances)
module tb_ws_led_tx;

`ifdef WS_LED_TX_PREFETCH_EN
    localparam bit PF = 1'b1;
`else
    localparam bit PF = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        s_valid;
    logic        s_ready;
    logic [3:0]  s_data;
    logic        s_last;
    logic        dout;
    logic        busy;

    logic        d_valid;
    logic        d_ready;
    logic [23:0] d_data;
    logic        d_last;
    logic        d_dout;
    logic        d_busy;

    int errors = 0;
    int checks = 0;

    logic [127:0] dq_v, rq_v, bq_v, exp_v;
    int           acc_idx;

    ws_led_tx #(.BITS(4), .T0H_CYC(2), .T1H_CYC(4), .BIT_CYC(6), .RESET_CYC(10)) u_dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_last(s_last), .dout(dout), .busy(busy)
    );

    ws_led_tx u_def (
        .clk(clk), .rst(rst), .s_valid(d_valid), .s_ready(d_ready),
        .s_data(d_data), .s_last(d_last), .dout(d_dout), .busy(d_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected small-parameter waveform of one word placed at cycle offset off.
    task automatic exp_word(input int off, input logic [3:0] w);
        int hi;
        for (int b = 0; b < 4; b++) begin
            hi = w[3-b] ? 4 : 2;
            for (int c = 0; c < hi; c++) exp_v[off + b*6 + c] = 1'b1;
        end
    endtask

    task automatic start_word(input logic [3:0] w, input logic l);
        int k;
        k = 0;
        @(negedge clk);
        while (!s_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!s_ready) begin
            checks++;
            errors++;
            $display("FAIL start_word: s_ready=%b after %0d cycles, required 1", s_ready, k);
        end
        s_valid = 1'b1;
        s_data  = w;
        s_last  = l;
    endtask

    // Record dout/s_ready/busy at negedges after the first word's transfer edge (index 0).
    task automatic capture(input int n, input int present_at, input logic [3:0] w2, input logic l2);
        logic pend;
        pend    = 1'b1;
        acc_idx = -1;
        dq_v = '0; rq_v = '0; bq_v = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            dq_v[i] = dout;
            rq_v[i] = s_ready;
            bq_v[i] = busy;
            if (pend) begin
                s_valid = 1'b0;
                pend    = 1'b0;
            end
            if (i == present_at) begin
                s_valid = 1'b1;
                s_data  = w2;
                s_last  = l2;
            end
            if (s_valid && s_ready) begin
                pend = 1'b1;
                if (acc_idx < 0) acc_idx = i;
            end
        end
        s_valid = 1'b0;
    endtask

    task automatic wait_idle;
        int k;
        k = 0;
        while (busy && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, k);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({dout, busy, s_ready} !== 3'b000) begin
            errors++;
            $display("FAIL reset_small: dout/busy/s_ready=%b required 000", {dout, busy, s_ready});
        end
        checks++;
        if ({d_dout, d_busy, d_ready} !== 3'b000) begin
            errors++;
            $display("FAIL reset_default: dout/busy/s_ready=%b required 000", {d_dout, d_busy, d_ready});
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (s_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: s_ready=%b required 1", s_ready);
        end
    endtask

    task automatic test_single_word;
        start_word(4'b1010, 1'b1);
        capture(40, -1, 4'h0, 1'b0);
        checks++;
        if (dq_v !== 128'h19E19E) begin
            errors++;
            $display("FAIL single_dout: got %h required %h", dq_v, 128'h19E19E);
        end
        checks++;
        if (bq_v !== 128'h3_FFFF_FFFF) begin
            errors++;
            $display("FAIL single_busy: got %h required %h", bq_v, 128'h3_FFFF_FFFF);
        end
        wait_idle();
    endtask

    task automatic test_back_to_back;
        int e_end;
        start_word(4'hF, 1'b0);
        capture(64, 0, 4'h0, 1'b1);
        exp_v = '0;
        exp_word(1, 4'hF);
        exp_word(PF ? 25 : 26, 4'h0);
        checks++;
        if (dq_v !== exp_v) begin
            errors++;
            $display("FAIL b2b_dout: got %h required %h", dq_v, exp_v);
        end
        checks++;
        if (acc_idx !== (PF ? 0 : 24)) begin
            errors++;
            $display("FAIL b2b_accept_cycle: got %0d required %0d", acc_idx, PF ? 0 : 24);
        end
        e_end = PF ? 58 : 59;
        checks++;
        if ({bq_v[e_end-1], bq_v[e_end]} !== 2'b10) begin
            errors++;
            $display("FAIL b2b_busy_end: got %b required 10", {bq_v[e_end-1], bq_v[e_end]});
        end
        wait_idle();
    endtask

    task automatic test_backpressure;
        start_word(4'hF, 1'b0);
        capture(64, 5, 4'h5, 1'b1);
        checks++;
        if (acc_idx !== (PF ? 5 : 24)) begin
            errors++;
            $display("FAIL bp_accept_cycle: got %0d required %0d", acc_idx, PF ? 5 : 24);
        end
        checks++;
        if (rq_v[6] !== 1'b0) begin
            errors++;
            $display("FAIL bp_ready_mid: s_ready=%b required 0", rq_v[6]);
        end
        checks++;
        if ({rq_v[23], rq_v[24]} !== 2'b01) begin
            errors++;
            $display("FAIL bp_ready_release: got %b required 01", {rq_v[23], rq_v[24]});
        end
        exp_v = '0;
        exp_word(1, 4'hF);
        exp_word(PF ? 25 : 26, 4'h5);
        checks++;
        if (dq_v !== exp_v) begin
            errors++;
            $display("FAIL bp_dout: got %h required %h", dq_v, exp_v);
        end
        wait_idle();
    endtask

    task automatic test_reset_abort;
        logic pend;
        logic pre_dout;
        logic idle_busy;
        start_word(4'hF, 1'b1);
        pend     = 1'b1;
        pre_dout = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (i == 6) pre_dout = dout;
            if (pend) begin
                s_valid = 1'b0;
                pend    = 1'b0;
            end
            if (i == 2) begin
                s_valid = 1'b1;
                s_data  = 4'h5;
                s_last  = 1'b1;
            end
            if (s_valid && s_ready) pend = 1'b1;
            if (i == 6) begin
                rst     = 1'b1;
                s_valid = 1'b0;
            end
        end
        checks++;
        if (pre_dout !== 1'b0) begin
            errors++;
            $display("FAIL abort_pre_dout: dout=%b required 0", pre_dout);
        end
        @(negedge clk);
        checks++;
        if ({dout, busy, s_ready} !== 3'b000) begin
            errors++;
            $display("FAIL abort_state: dout/busy/s_ready=%b required 000", {dout, busy, s_ready});
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({s_ready, busy} !== 2'b10) begin
            errors++;
            $display("FAIL abort_release: s_ready/busy=%b required 10", {s_ready, busy});
        end
        idle_busy = 1'b0;
        repeat (3) begin
            @(negedge clk);
            idle_busy = idle_busy | busy | dout;
        end
        checks++;
        if (idle_busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_discard: busy|dout=%b required 0", idle_busy);
        end
        start_word(4'b1010, 1'b1);
        capture(40, -1, 4'h0, 1'b0);
        checks++;
        if (dq_v !== 128'h19E19E) begin
            errors++;
            $display("FAIL abort_restart_dout: got %h required %h", dq_v, 128'h19E19E);
        end
        wait_idle();
    endtask

    task automatic test_default_params;
        logic [0:599] dw;
        logic [23:0]  word6;
        int latch_ones, hi, exp_hi, k;
        logic seen_low, bad, busy_a, busy_b;
        word6 = 24'hFF00AA;
        latch_ones = 0;
        busy_a = 1'b0;
        busy_b = 1'b1;
        k = 0;
        @(negedge clk);
        while (!d_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        d_valid = 1'b1;
        d_data  = word6;
        d_last  = 1'b1;
        for (int i = 0; i <= 6600; i++) begin
            @(negedge clk);
            if (i == 0) d_valid = 1'b0;
            if (i >= 1 && i <= 600) dw[i-1] = d_dout;
            else if (i > 600 && d_dout) latch_ones++;
            if (i == 6599) busy_a = d_busy;
            if (i == 6600) busy_b = d_busy;
        end
        for (int b = 0; b < 24; b++) begin
            hi = 0;
            seen_low = 1'b0;
            bad = 1'b0;
            for (int c = 0; c < 25; c++) begin
                if (dw[b*25 + c]) begin
                    if (seen_low) bad = 1'b1;
                    else hi++;
                end else begin
                    seen_low = 1'b1;
                end
            end
            exp_hi = word6[23-b] ? 16 : 8;
            checks++;
            if (bad || hi != exp_hi) begin
                errors++;
                $display("FAIL default_bit%0d_high: got %0d (split=%b) required %0d", b, hi, bad, exp_hi);
            end
        end
        checks++;
        if (latch_ones != 0) begin
            errors++;
            $display("FAIL default_latch_low: high cycles=%0d required 0", latch_ones);
        end
        checks++;
        if ({busy_a, busy_b} !== 2'b10) begin
            errors++;
            $display("FAIL default_latch_len: busy@6599/6600=%b required 10", {busy_a, busy_b});
        end
    endtask

    initial begin
        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = 4'h0;
        s_last  = 1'b0;
        d_valid = 1'b0;
        d_data  = 24'h0;
        d_last  = 1'b0;
        test_reset();
        test_single_word();
        test_back_to_back();
        test_backpressure();
        test_reset_abort();
        test_default_params();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
